// File: rtl/psum_accumulator_pkg.sv
// rtl/psum_accumulator_pkg.sv - shared state type and default sizes for psum_accumulator
`include "psum_acc_defs.vh"

package psum_accumulator_pkg;

    typedef enum logic [1:0] {
        IDLE  = `ST_IDLE,
        ACCUM = `ST_ACCUM,
        HOLD  = `ST_HOLD
    } state_e;

    localparam int LANES_DEF  = 16;
    localparam int PSUM_W_DEF = 24;
    localparam int ACC_W_DEF  = 32;
    localparam int CNT_W_DEF  = 5;

endpackage

// File: rtl/psum_acc_defs.vh
// rtl/psum_acc_defs.vh - state encodings and lane-slice helpers for psum_accumulator
`ifndef PSUM_ACC_DEFS_VH
`define PSUM_ACC_DEFS_VH

`define ST_IDLE  2'd0
`define ST_ACCUM 2'd1
`define ST_HOLD  2'd2

// Select lane i of width w from a flat lane-packed vector
`define PSUM_LANE(vec, i, w) vec[(i)*(w) +: (w)]

`endif

// File: rtl/psum_lane_add.sv
// rtl/psum_lane_add.sv - one lane: sign-extend partial sum and add (saturating under PSUM_ACC_SAT_EN)
module psum_lane_add #(
    parameter int PSUM_W = 24,
    parameter int ACC_W  = 32
) (
    input  logic signed [ACC_W-1:0]  acc_i,
    input  logic signed [PSUM_W-1:0] psum_i,
    output logic        [ACC_W-1:0]  sum_o
`ifdef PSUM_ACC_SAT_EN
    ,
    output logic                     sat_o
`endif
);

    logic [ACC_W-1:0] ext;
    logic [ACC_W-1:0] raw;

    assign ext = ACC_W'(psum_i);
    assign raw = acc_i + ext;

`ifdef PSUM_ACC_SAT_EN
    logic ovf;

    // Overflow only when both operands share a sign and the result flips it
    always_comb begin
        ovf   = (acc_i[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc_i[ACC_W-1]);
        sat_o = ovf;
        sum_o = raw;
        if (ovf) begin
            sum_o = acc_i[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign sum_o = raw;
`endif

endmodule

// File: rtl/psum_accumulator.sv
// rtl/psum_accumulator.sv - multi-pass partial-sum collector with one-entry output buffer (PSUM_ACC_SAT_EN selects saturation)
`include "psum_acc_defs.vh"

module psum_accumulator
    import psum_accumulator_pkg::*;
#(
    parameter int LANES  = LANES_DEF,
    parameter int PSUM_W = PSUM_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [CNT_W-1:0]          num_passes,
    input  logic                      psum_valid,
    input  logic [LANES*PSUM_W-1:0]   psum_in,
    output logic                      stall,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*ACC_W-1:0]    out_data,
    output logic                      busy,
    output logic                      tile_done,
    output logic                      overflow
);

    state_e                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]         npass_q, npass_d;
    logic [LANES*ACC_W-1:0]   acc_q, acc_d;
    logic [LANES*ACC_W-1:0]   out_data_q, out_data_d;
    logic                     out_valid_q, out_valid_d;
    logic                     tile_done_q, tile_done_d;
    logic [LANES*ACC_W-1:0]   sum_w;
    logic                     buf_free;
    logic                     beat;

`ifdef PSUM_ACC_SAT_EN
    logic [LANES-1:0]         sat_w;
    logic                     ovf_q, ovf_d;
`endif

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            psum_lane_add #(
                .PSUM_W (PSUM_W),
                .ACC_W  (ACC_W)
            ) u_add (
                .acc_i  (`PSUM_LANE(acc_q, g, ACC_W)),
                .psum_i (`PSUM_LANE(psum_in, g, PSUM_W)),
                .sum_o  (`PSUM_LANE(sum_w, g, ACC_W))
`ifdef PSUM_ACC_SAT_EN
                ,
                .sat_o  (sat_w[g])
`endif
            );
        end
    endgenerate

    // The buffer can take a new tile if empty or being drained this cycle
    assign buf_free = !out_valid_q || out_ready;
    assign beat     = (state_q == ACCUM) && psum_valid;

    // Next-state: tile sequencing, pass counting and output-buffer loading
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        npass_d     = npass_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q && !out_ready;
        tile_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    acc_d   = '0;
                    cnt_d   = '0;
                    npass_d = (num_passes == '0) ? CNT_W'(1) : num_passes;
                end
            end
            ACCUM: begin
                if (psum_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    acc_d = sum_w;
                    if (cnt_q == npass_q - CNT_W'(1)) begin
                        if (buf_free) begin
                            out_data_d  = sum_w;
                            out_valid_d = 1'b1;
                            tile_done_d = 1'b1;
                            state_d     = IDLE;
                        end else begin
                            state_d = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (buf_free) begin
                    out_data_d  = acc_q;
                    out_valid_d = 1'b1;
                    tile_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            npass_q     <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            npass_q     <= npass_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            tile_done_q <= tile_done_d;
        end
    end

`ifdef PSUM_ACC_SAT_EN
    // Sticky saturation flag, cleared when a new tile is started
    always_comb begin
        ovf_d = ovf_q | (beat && (|sat_w));
        if (state_q == IDLE && start) begin
            ovf_d = 1'b0;
        end
    end

    // Saturation flag register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign stall     = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign tile_done = tile_done_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// tb/tb_psum_accumulator.sv - self-checking bench for psum_accumulator
module tb_psum_accumulator;

    localparam int LANES  = 16;
    localparam int PSUM_W = 24;
    localparam int ACC_W  = 32;
    localparam int CNT_W  = 5;
    localparam int NRAND  = 30;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     start;
    logic [CNT_W-1:0]         num_passes;
    logic                     psum_valid;
    logic [LANES*PSUM_W-1:0]  psum_in;
    logic                     stall;
    logic                     out_valid;
    logic                     out_ready;
    logic [LANES*ACC_W-1:0]   out_data;
    logic                     busy;
    logic                     tile_done;
    logic                     overflow;

    psum_accumulator #(
        .LANES  (LANES),
        .PSUM_W (PSUM_W),
        .ACC_W  (ACC_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_passes (num_passes),
        .psum_valid (psum_valid),
        .psum_in    (psum_in),
        .stall      (stall),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .tile_done  (tile_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          np;
        int          v0;
        int          vr;
        logic [31:0] e0;
        logic [31:0] er;
        bit          spur;
    } vec_t;

    int total = 0;
    int bad   = 0;
    bit rdy_rand = 0;
    bit mon_en   = 0;
    int td_cnt   = 0;
    logic [LANES*ACC_W-1:0] exp_q[$];

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    task automatic chkw(input string nm, input logic [LANES*ACC_W-1:0] a, input logic [LANES*ACC_W-1:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    function automatic logic [31:0] lane(input int i);
        return out_data[i*ACC_W +: ACC_W];
    endfunction

    task automatic step();
        @(negedge clk);
        if (rdy_rand) out_ready = ($urandom_range(0, 2) != 0);
    endtask

    task automatic set_lanes(input int v0, input int vr);
        psum_in[PSUM_W-1:0] = 24'(v0);
        for (int i = 1; i < LANES; i++) psum_in[i*PSUM_W +: PSUM_W] = 24'(vr);
    endtask

    // One tile with uniform beats, out_ready held high
    task automatic run_tile(input vec_t t);
        int nb;
        nb = (t.np == 0) ? 1 : t.np;
        if (t.spur) begin
            step(); set_lanes(12345, -999); psum_valid = 1;
            step(); chk("idle_psum_busy", busy, 0);
            step(); psum_valid = 0; chk("idle_psum_valid", out_valid, 0);
        end
        step(); start = 1; num_passes = CNT_W'(t.np); psum_valid = 0;
        for (int b = 0; b < nb; b++) begin
            step();
            start = (t.spur && b == 1);
            if (t.spur && b == 1) num_passes = CNT_W'(1);
            set_lanes(t.v0, t.vr);
            psum_valid = 1;
            if (b == nb - 1) chk("pre_valid", out_valid, 0);
        end
        step(); psum_valid = 0; start = 0;
        chk("out_valid", out_valid, 1);
        chk("tile_done", tile_done, 1);
        chk("busy_after", busy, 0);
        chk("lane0", lane(0), t.e0);
        chk("lane15", lane(15), t.er);
        chk("overflow", overflow, 0);
        step();
        chk("drained", out_valid, 0);
        chk("td_pulse", tile_done, 0);
    endtask

    // Scoreboard: every accepted tile compared in order, held data must not move
    initial begin
        logic                   hold_prev = 0;
        logic [LANES*ACC_W-1:0] prev_data = '0;
        logic [LANES*ACC_W-1:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && rst_n) begin
                if (tile_done) td_cnt++;
                if (hold_prev) chkw("stable", out_data, prev_data);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) chk("unexpected_out", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chkw("rand_tile", out_data, e);
                    end
                end
                hold_prev = out_valid && !out_ready;
                prev_data = out_data;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[5];
        vec_t t;
        logic [LANES*PSUM_W-1:0] beats[8];
        longint sums[LANES];
        logic [LANES*ACC_W-1:0] e;
        logic [PSUM_W-1:0] v;
        int np, nb, idx, wc;

        tbl[0] = '{4, 100, 100, 32'd400, 32'd400, 1'b0};
        tbl[1] = '{0, -5, 0, 32'hFFFFFFFB, 32'd0, 1'b0};
        tbl[2] = '{3, -8388608, 8388607, 32'hFE800000, 32'h017FFFFD, 1'b0};
        tbl[3] = '{2, 1, -1, 32'd2, 32'hFFFFFFFE, 1'b0};
        tbl[4] = '{4, 100, 100, 32'd400, 32'd400, 1'b1};

        rst_n = 0; start = 0; num_passes = '0; psum_valid = 0; psum_in = '0; out_ready = 1;
        step(); step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall, 0);
        chk("rst_tile_done", tile_done, 0);
        chk("rst_overflow", overflow, 0);
        chkw("rst_out_data", out_data, '0);
        rst_n = 1;

        for (int k = 0; k < 5; k++) run_tile(tbl[k]);

        // Final beat while the buffer is still full parks the tile in HOLD
        out_ready = 0;
        step(); start = 1; num_passes = 5'd1;
        step(); start = 0; set_lanes(3, 3); psum_valid = 1;
        step(); psum_valid = 0;
        chk("a_valid", out_valid, 1);
        chk("a_lane0", lane(0), 32'd3);
        start = 1; num_passes = 5'd2;
        step(); start = 0; set_lanes(1, 1); psum_valid = 1;
        chk("b_no_stall", stall, 0);
        step();
        step(); psum_valid = 0;
        chk("b_stall", stall, 1);
        chk("b_busy", busy, 1);
        chk("a_held", lane(0), 32'd3);
        chk("b_no_done", tile_done, 0);
        step();
        chk("b_stall2", stall, 1);
        chk("a_held2", lane(5), 32'd3);
        out_ready = 1; start = 1; num_passes = 5'd3;
        step(); start = 0;
        chk("b_valid", out_valid, 1);
        chk("b_lane0", lane(0), 32'd2);
        chk("b_done", tile_done, 1);
        chk("b_stall_clr", stall, 0);
        chk("start_on_xfer_ignored", busy, 0);
        step();
        chk("b_drained", out_valid, 0);

        // Reset mid-tile with a full buffer
        out_ready = 0;
        step(); start = 1; num_passes = 5'd1;
        step(); start = 0; set_lanes(5, 5); psum_valid = 1;
        step(); psum_valid = 0; start = 1; num_passes = 5'd4;
        step(); start = 0; set_lanes(9, 9); psum_valid = 1;
        step();
        step(); psum_valid = 0;
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_valid", out_valid, 1);
        rst_n = 0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_busy", busy, 0);
        step();
        chkw("rst_data", out_data, '0);
        rst_n = 1; out_ready = 1;
        t = '{1, 7, 7, 32'd7, 32'd7, 1'b0};
        run_tile(t);

        // Randomised tiles against an arithmetic model
        rdy_rand = 1;
        mon_en = 1;
        for (int tn = 0; tn < NRAND; tn++) begin
            np = $urandom_range(0, 6);
            nb = (np == 0) ? 1 : np;
            for (int l = 0; l < LANES; l++) sums[l] = 0;
            for (int b = 0; b < nb; b++) begin
                for (int l = 0; l < LANES; l++) begin
                    v = PSUM_W'($urandom);
                    beats[b][l*PSUM_W +: PSUM_W] = v;
                    sums[l] += longint'($signed(v));
                end
            end
            for (int l = 0; l < LANES; l++) e[l*ACC_W +: ACC_W] = sums[l][ACC_W-1:0];
            exp_q.push_back(e);
            step(); psum_valid = 0;
            wc = 0;
            while (busy && wc < 200) begin step(); wc++; end
            chk("idle_wait", busy, 0);
            start = 1; num_passes = CNT_W'(np);
            idx = 0; wc = 0;
            while (idx < nb && wc < 500) begin
                step(); start = 0; wc++;
                if ($urandom_range(0, 3) == 0) begin
                    psum_valid = 0;
                    psum_in = {LANES{24'hA5A5A5}};
                end else begin
                    psum_valid = 1;
                    psum_in = beats[idx];
                    if (!stall) idx++;
                end
            end
        end
        step(); psum_valid = 0;
        wc = 0;
        while ((exp_q.size() != 0 || out_valid) && wc < 300) begin step(); wc++; end
        step();
        mon_en = 0;
        rdy_rand = 0;
        chk("queue_empty", exp_q.size(), 0);
        chk("tile_done_count", td_cnt, NRAND);
        chk("rand_overflow", overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
